data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the processor data-memory handshake (DataAddr/DataOut/WriteData/ReadData -> DataIn/DataDone).
//  Sits between the processor data port and a synchronous single-port RAM (inst_mem-style, registered address, 1-cycle read).
//  Inserts a programmable number of wait states, range-checks addresses and keeps access statistics.
//  Replaces ad-hoc wait-cycle logic in benches and top-levels.
// PARAMETERS
//  DATA_W      16  data width, processor and RAM
//  ADDR_W      12  RAM address width; DataAddr[15:ADDR_W] must be 0
//  WAIT_CYCLES 1   cycles DataDone is held low per access; legal range 1..15
//  CNT_W       16  width of access counters
// PORTS
//  Clock      in   1       system clock, all state on posedge
//  ResetN     in   1       asynchronous, active-low reset
//  DataAddr   in   16      processor byte/word address, sampled at accept edge
//  DataOut    in   DATA_W  processor write data, sampled at accept edge
//  WriteData  in   1       write request
//  ReadData   in   1       read request
//  DataIn     out  DATA_W  read data to processor (registered, held)
//  DataDone   out  1       1 = idle / previous access complete; 0 = busy
//  MemAddr    out  ADDR_W  RAM address
//  MemWData   out  DATA_W  RAM write data
//  MemWren    out  1       RAM write enable
//  MemRData   in   DATA_W  RAM read data (valid one edge after address sampled)
//  AddrErr    out  1       sticky: an out-of-range access was accepted
//  ProtoErr   out  1       sticky: ReadData and WriteData both high at an accept edge
//  RdCount    out  CNT_W   accepted reads, wraps modulo 2^CNT_W
//  WrCount    out  CNT_W   accepted writes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (ResetN=0, async): state IDLE, DataDone=1, DataIn=0, AddrErr=ProtoErr=0, RdCount=WrCount=0, cnt=0.
//  MemWren forced 0 while ResetN=0.
//  States: IDLE, BUSY.  DataDone = (state==IDLE).
//  IDLE: MemAddr=DataAddr[ADDR_W-1:0], MemWData=DataOut, MemWren=WriteData & in_range (combinational).
//  Accept edge: posedge in IDLE with (ReadData|WriteData): capture op, addr, in_range; -> BUSY, cnt<=WAIT_CYCLES-1.
//   Write is committed to RAM at the accept edge itself; read address is sampled by RAM at the same edge.
//   in_range = (DataAddr[15:ADDR_W]==0).  Out of range: no RAM write, AddrErr<=1, read returns 0.
//   Both requests high: treated as write, ProtoErr<=1, only WrCount increments.
//   RdCount/WrCount increment at accept edge (out-of-range accesses still counted).
//  BUSY: MemAddr=addr_q, MemWren=0; requests ignored.
//   cnt!=0 -> cnt<=cnt-1.  cnt==0 -> IDLE; if read: DataIn<=in_range_q ? MemRData : 0.
//  Latency: DataDone low for exactly WAIT_CYCLES cycles after accept edge; DataIn valid when DataDone rises.
//  DataIn holds last read value through writes and idle cycles.
//  Back-to-back: a request still high in the first IDLE cycle after completion is a new access (initiator drops it).
//  Reset mid-BUSY: access abandoned, a write already committed stays in RAM, DataIn=0.
// STRUCTURE
//  Package mem_if_pkg: typedef enum logic {IDLE,BUSY} resp_state_t; DATA_W/ADDR_W defaults; DONE_ERR_DATA ('0).
//  No sub-module; single always_ff for state/cnt/regs, single always_comb for RAM-side drive. RAM instanced outside.
// TESTING
//  1 Write 16'h1234 @0x0010, then read @0x0010 (WAIT_CYCLES=1) -> MemWren 1 cycle, DataDone low 1 cycle each, DataIn=16'h1234.
//  2 WAIT_CYCLES=3, read @0x0020 holding 16'hBEEF -> DataDone low exactly 3 cycles, DataIn=16'hBEEF as DataDone rises.
//  3 Write @0x1010 data 16'h5555 -> MemWren stays 0, AddrErr=1, RAM[0x010] unchanged; read @0x1010 -> DataIn=0.
//  4 ReadData=WriteData=1 @0x0030 data 16'hA5A5 -> RAM[0x030]=16'hA5A5, ProtoErr=1, WrCount+1, RdCount unchanged.
//  5 ResetN low during BUSY of a read -> DataDone=1, DataIn=0, counters 0 immediately (no clock edge needed).
//  6 CNT_W=4, 17 reads -> RdCount=1 (wrap); requests toggled while BUSY -> no extra accepts.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the processor data-memory handshake responder.
package mem_if_pkg;

  typedef enum logic {IDLE, BUSY} resp_state_t;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 12;
  // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [DATA_W_DEF-1:0] DONE_ERR_DATA = '0;

endpackage

// File: rtl/data_mem_responder.sv
// Responder for the processor data-memory handshake: wait-state insertion, address range
// checking and access statistics in front of a synchronous 1-cycle-read single-port RAM.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [15:0]       DataAddr,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              WriteData,
  input  logic              ReadData,
  output logic [DATA_W-1:0] DataIn,
  output logic              DataDone,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWren,
  input  logic [DATA_W-1:0] MemRData,
  output logic              AddrErr,
  output logic              ProtoErr,
  output logic [CNT_W-1:0]  RdCount,
  output logic [CNT_W-1:0]  WrCount
);

  resp_state_t           r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_op_wr;
  logic                  r_in_range;
  logic [ADDR_W-1:0]     r_addr;

  logic w_in_range;
  logic w_req;

  // ADDR_W must be below 16 so that at least one upper address bit exists.
  assign w_in_range = (DataAddr[15:ADDR_W] == '0);
  assign w_req      = ReadData | WriteData;
  assign DataDone   = (r_state == IDLE);

  // Idle passes the request straight through so the RAM commits/samples on the accept edge.
  always_comb begin
    MemAddr  = r_addr;
    MemWData = DataOut;
    MemWren  = 1'b0;
    if (r_state == IDLE) begin
      MemAddr = DataAddr[ADDR_W-1:0];
      MemWren = WriteData & w_in_range & ResetN;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op_wr    <= 1'b0;
      r_in_range <= 1'b0;
      r_addr     <= '0;
      DataIn     <= '0;
      AddrErr    <= 1'b0;
      ProtoErr   <= 1'b0;
      RdCount    <= '0;
      WrCount    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state    <= BUSY;
            r_cnt      <= WAIT_CNT_W'(WAIT_CYCLES - 1);
            r_op_wr    <= WriteData;
            r_addr     <= DataAddr[ADDR_W-1:0];
            r_in_range <= w_in_range;
            if (!w_in_range) AddrErr <= 1'b1;
            // A simultaneous read+write resolves to a write.
            if (WriteData) begin
              WrCount <= WrCount + CNT_W'(1);
              if (ReadData) ProtoErr <= 1'b1;
            end else begin
              RdCount <= RdCount + CNT_W'(1);
            end
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
          end else begin
            r_state <= IDLE;
            if (!r_op_wr) DataIn <= r_in_range ? MemRData : DATA_W'(DONE_ERR_DATA);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int unsigned WAIT    = 3;
  localparam int unsigned CW      = 4;
  localparam int unsigned MEM_WIN = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] DataAddr;
  logic [15:0] DataOut;
  logic        WriteData;
  logic        ReadData;
  logic [15:0] DataIn;
  logic        DataDone;
  logic [11:0] MemAddr;
  logic [15:0] MemWData;
  logic        MemWren;
  logic [15:0] MemRData;
  logic        AddrErr;
  logic        ProtoErr;
  logic [CW-1:0] RdCount;
  logic [CW-1:0] WrCount;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_W      (16),
    .ADDR_W      (12),
    .WAIT_CYCLES (WAIT),
    .CNT_W       (CW)
  ) u_dut (
    .Clock     (clk),
    .ResetN    (rst_n),
    .DataAddr  (DataAddr),
    .DataOut   (DataOut),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .DataIn    (DataIn),
    .DataDone  (DataDone),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemWren   (MemWren),
    .MemRData  (MemRData),
    .AddrErr   (AddrErr),
    .ProtoErr  (ProtoErr),
    .RdCount   (RdCount),
    .WrCount   (WrCount)
  );

  // Synchronous RAM with registered address, plus a preload port for the bench.
  logic [15:0] ram [4096];
  logic [11:0] ram_addr_q;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [15:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (MemWren) ram[MemAddr] <= MemWData;
    ram_addr_q <= MemAddr;
  end
  assign MemRData = ram[ram_addr_q];

  // Reference model state
  logic [15:0] exp_mem [4096];
  int          m_rd;
  int          m_wr;
  logic        m_ae;
  logic        m_pe;
  logic [15:0] m_din;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd  = 0;
    m_wr  = 0;
    m_ae  = 1'b0;
    m_pe  = 1'b0;
    m_din = 16'h0;
  endtask

  task automatic model_accept(input logic [15:0] a, input logic [15:0] d, input logic rd,
                              input logic wr);
    logic inr;
    inr = (a < 16'h1000);
    if (!inr) m_ae = 1'b1;
    if (wr) begin
      m_wr++;
      if (rd) m_pe = 1'b1;
      if (inr) exp_mem[a[11:0]] = d;
    end else begin
      m_rd++;
      m_din = inr ? exp_mem[a[11:0]] : 16'h0;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_din"},   32'(DataIn),   32'(m_din));
    check_eq({tag, "_rdcnt"}, 32'(RdCount),  32'(m_rd % (1 << CW)));
    check_eq({tag, "_wrcnt"}, 32'(WrCount),  32'(m_wr % (1 << CW)));
    check_eq({tag, "_aerr"},  32'(AddrErr),  32'(m_ae));
    check_eq({tag, "_perr"},  32'(ProtoErr), 32'(m_pe));
  endtask

  task automatic do_txn(input logic [15:0] a, input logic [15:0] d, input logic rd,
                        input logic wr);
    int   busy;
    logic wren_busy;
    logic done;
    logic inr;
    inr = (a < 16'h1000);
    @(negedge clk);
    DataAddr  = a;
    DataOut   = d;
    ReadData  = rd;
    WriteData = wr;
    #1;
    check_eq("idle_done",  32'(DataDone), 32'(1));
    check_eq("idle_wren",  32'(MemWren),  32'(wr & inr));
    check_eq("idle_maddr", 32'(MemAddr),  32'(a[11:0]));
    check_eq("idle_wdata", 32'(MemWData), 32'(d));
    @(posedge clk);
    model_accept(a, d, rd, wr);
    busy      = 0;
    wren_busy = 1'b0;
    done      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (DataDone) begin
        ReadData  = 1'b0;
        WriteData = 1'b0;
        done      = 1'b1;
      end else begin
        busy++;
        if (MemWren) wren_busy = 1'b1;
        // Requests and address wander while busy; all must be ignored.
        ReadData  = 1'($urandom);
        WriteData = 1'($urandom);
        DataAddr  = 16'($urandom);
        DataOut   = 16'($urandom);
      end
    end
    check_eq("done_timeout", 32'(DataDone),  32'(1));
    check_eq("busy_cycles",  32'(busy),      32'(WAIT));
    check_eq("busy_wren",    32'(wren_busy), 32'(0));
    check_state("txn");
    if (wr) check_eq("ram_word", 32'(ram[a[11:0]]), 32'(exp_mem[a[11:0]]));
  endtask

  task automatic reset_mid(input logic [15:0] a, input logic [15:0] d, input logic rd,
                           input logic wr);
    @(negedge clk);
    DataAddr  = a;
    DataOut   = d;
    ReadData  = rd;
    WriteData = wr;
    @(posedge clk);
    model_accept(a, d, rd, wr);
    @(negedge clk);
    check_eq("pre_rst_busy", 32'(DataDone), 32'(0));
    rst_n     = 1'b0;
    WriteData = 1'b1;
    #1;
    model_reset();
    check_eq("rst_done", 32'(DataDone), 32'(1));
    check_eq("rst_wren", 32'(MemWren),  32'(0));
    check_state("rst");
    @(negedge clk);
    rst_n     = 1'b1;
    ReadData  = 1'b0;
    WriteData = 1'b0;
    check_eq("rst_ram", 32'(ram[a[11:0]]), 32'(exp_mem[a[11:0]]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic        rd;
    logic        wr;
    int          sel;
    rst_n     = 1'b0;
    DataAddr  = 16'h0010;
    DataOut   = 16'hFFFF;
    ReadData  = 1'b0;
    WriteData = 1'b1;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    model_reset();
    #1;
    check_eq("reset_done", 32'(DataDone), 32'(1));
    check_eq("reset_wren", 32'(MemWren),  32'(0));
    check_state("reset");

    // Preload the working window while held in reset.
    WriteData = 1'b0;
    for (int i = 0; i < int'(MEM_WIN); i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 12'(i);
      ld_data = (i == 32) ? 16'hBEEF : 16'($urandom);
      exp_mem[i] = ld_data;
    end
    @(negedge clk);
    ld_en = 1'b0;
    rst_n = 1'b1;

    do_txn(16'h0010, 16'h1234, 1'b0, 1'b1);
    do_txn(16'h0010, 16'h0000, 1'b1, 1'b0);
    check_eq("rd_after_wr", 32'(DataIn), 32'(16'h1234));
    do_txn(16'h0020, 16'h0000, 1'b1, 1'b0);
    check_eq("rd_beef", 32'(DataIn), 32'(16'hBEEF));
    do_txn(16'h1010, 16'h5555, 1'b0, 1'b1);
    check_eq("oor_ram_kept", 32'(ram[12'h010]), 32'(16'h1234));
    do_txn(16'h1010, 16'h0000, 1'b1, 1'b0);
    do_txn(16'h0030, 16'hA5A5, 1'b1, 1'b1);
    check_eq("both_ram", 32'(ram[12'h030]), 32'(16'hA5A5));

    reset_mid(16'h0020, 16'h0000, 1'b1, 1'b0);
    reset_mid(16'h0005, 16'h7E57, 1'b0, 1'b1);

    for (int k = 0; k < 17; k++) do_txn(16'($urandom_range(0, MEM_WIN - 1)), 16'h0, 1'b1, 1'b0);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) a = {4'($urandom_range(1, 15)), 6'b0, 6'($urandom)};
      else a = 16'($urandom_range(0, MEM_WIN - 1));
      sel = $urandom_range(0, 9);
      rd  = (sel < 5) || (sel == 9);
      wr  = (sel >= 5);
      do_txn(a, 16'($urandom), rd, wr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
